// File: rtl/serial_adder_seq_pkg.sv
// serial_adder_seq_pkg: shared state encoding, default width and counter sizing for the bit-serial adder
package serial_adder_seq_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_seq_if.sv
// serial_adder_seq_if: request/result bundle of the bit-serial adder
//   master drives start/sub/a/b; slave drives busy/done/sum/c_out/ofl
interface serial_adder_seq_if
  import serial_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ofl;
  modport master(output start, sub, a, b, input busy, done, sum, c_out, ofl);
  modport slave(input start, sub, a, b, output busy, done, sum, c_out, ofl);
endinterface

// File: rtl/fullAdder_1b.sv
// fullAdder_1b: single-bit full-adder cell
//   a_i/b_i/c_i operand and carry in; s_o sum bit; c_o carry out
module fullAdder_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle LSB-first bit-serial adder/subtractor through one full-adder cell
//   clk, rst_n (sync, active-low); bus: start/sub/a/b in, busy/done/sum/c_out/ofl out
module serial_adder_seq
  import serial_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  serial_adder_seq_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, ofl_q, ofl_d, fa_s, fa_c;
  fullAdder_1b u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(c_q), .s_o(fa_s), .c_o(fa_c));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ofl_d   = ofl_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = bus.start ? RUN : IDLE;
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.sub ? ~bus.b : bus.b;
          c_d   = bus.sub;
          cnt_d = '0;
        end
      end
      RUN: begin
        p_d   = {fa_s, p_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        // On the MSB step the carry flop holds the carry into the MSB, so it is the msb_cin term of the overflow
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {fa_s, p_q[WIDTH-1:1]};
          co_d    = fa_c;
          ofl_d   = c_q ^ fa_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ofl_q   <= ofl_d;
    end
  end
  assign bus.busy  = state_q == RUN;
  assign bus.done  = state_q == DONE;
  assign bus.sum   = sum_q;
  assign bus.c_out = co_q;
  assign bus.ofl   = ofl_q;
endmodule
